// File: rtl/net_resolve_pkg.sv
// net_resolve_pkg: shared net-kind and 4-state encodings plus the per-bit resolution rule.
package net_resolve_pkg;
  typedef enum logic [1:0] {NK_WIRE, NK_WOR, NK_WAND, NK_TRIREG} net_kind_e;
  typedef enum logic [1:0] {L0 = 2'b00, L1 = 2'b01, LZ = 2'b10, LX = 2'b11} logic4_e;
  function automatic logic4_e resolve_bit(input logic any0, input logic any1, input net_kind_e kind);
    return (!any0 && !any1) ? LZ :
           kind == NK_WOR   ? (any1 ? L1 : L0) :
           kind == NK_WAND  ? (any0 ? L0 : L1) :
           (any0 && any1)   ? LX : (any1 ? L1 : L0);
  endfunction
endpackage

// File: rtl/net_resolve_bit.sv
// net_resolve_bit: one resolved net bit with its registered state and, for trireg, charge decay.
module net_resolve_bit
  import net_resolve_pkg::*;
#(
  parameter int NDRV  = 4,
  parameter int MODE  = 0,
  parameter int DECAY = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [NDRV-1:0] en,
  input  logic [NDRV-1:0] val,
  output logic [1:0]      res,
  output logic            conflict
);
  localparam net_kind_e KIND = net_kind_e'(MODE[1:0]);
  if (DECAY < 0) begin : g_bad_decay
    $error("net_resolve_bit: DECAY must be >= 0");
  end
  logic any0, any1;
  logic4_e rb, st;
  assign any0 = |(en & ~val);
  assign any1 = |(en & val);
  assign rb = resolve_bit(any0, any1, KIND);
  assign conflict = rb == LX;
  assign res = st;
  if (KIND == NK_TRIREG) begin : g_tri
    localparam int CW = DECAY > 0 ? $clog2(DECAY + 1) : 1;
    localparam logic [CW-1:0] DMAX = CW'(DECAY);
    localparam logic [CW-1:0] DLAST = CW'(DECAY > 0 ? DECAY - 1 : 0);
    logic [CW-1:0] dc;
    // dc counts undriven accepted beats; it parks at DECAY once the charge is lost
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st <= LX;
        dc <= '0;
      end else if (in_valid && (any0 || any1)) begin
        st <= rb;
        dc <= '0;
      end else if (in_valid && DECAY != 0 && dc != DMAX) begin
        dc <= dc + 1'b1;
        if (dc == DLAST) st <= LX;
      end
  end else begin : g_comb
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= LZ;
      else if (in_valid) st <= rb;
  end
endmodule

// File: rtl/net_resolve_reg.sv
// net_resolve_reg: registered multi-driver net resolver (wire/wor/wand/trireg) with conflict tracking.
module net_resolve_reg
  import net_resolve_pkg::*;
#(
  parameter int NDRV  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int DECAY = 3,
  parameter int CNTW  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [NDRV-1:0][WIDTH-1:0]  drv_val,
  input  logic [NDRV-1:0][WIDTH-1:0]  drv_en,
  input  logic                        cnt_clr,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            res_v,
  output logic [WIDTH-1:0]            res_xz,
  output logic                        conflict,
  output logic [CNTW-1:0]             conflict_cnt
);
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("net_resolve_reg: MODE must be 0..3");
  end
  if (NDRV < 1 || NDRV > 16 || WIDTH < 1 || WIDTH > 64) begin : g_bad_size
    $error("net_resolve_reg: NDRV must be 1..16 and WIDTH 1..64");
  end
  logic [WIDTH-1:0] cf;
  genvar b, d;
  for (b = 0; b < WIDTH; b++) begin : g_bit
    logic [NDRV-1:0] e, v;
    logic [1:0] r;
    for (d = 0; d < NDRV; d++) begin : g_drv
      assign e[d] = drv_en[d][b];
      assign v[d] = drv_val[d][b];
    end
    net_resolve_bit #(.NDRV(NDRV), .MODE(MODE), .DECAY(DECAY)) u_bit (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .en(e),
      .val(v),
      .res(r),
      .conflict(cf[b])
    );
    assign res_xz[b] = r[1];
    assign res_v[b] = r[0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      conflict <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) conflict <= |cf;
      if (cnt_clr) conflict_cnt <= '0;
      else if (in_valid && |cf && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
    end
endmodule

// File: tb/tb_net_resolve_reg.sv
// tb_net_resolve_reg: four resolvers (one per net kind) on shared drivers, checked against a per-bit model.
module tb_net_resolve_reg;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cnt_clr = 1'b0;
  logic [1:0][7:0] dv = '0, de = '0;
  logic ov[4], cf[4];
  logic [7:0] rv[4], rx[4];
  logic [3:0] cc[4];
  int n_tests = 0, n_fail = 0;
  logic [1:0] em[4][8];
  int age[8];
  logic eov[4], ecf[4];
  logic [3:0] ecc[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    net_resolve_reg #(.NDRV(2), .WIDTH(8), .MODE(g), .DECAY(3), .CNTW(4)) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .drv_val(dv),
      .drv_en(de),
      .cnt_clr(cnt_clr),
      .out_valid(ov[g]),
      .res_v(rv[g]),
      .res_xz(rx[g]),
      .conflict(cf[g]),
      .conflict_cnt(cc[g])
    );
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_vec(input int m, input int k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = em[m][b][k];
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      for (int b = 0; b < 8; b++) em[m][b] = (m == 3) ? 2'b11 : 2'b10;
      eov[m] = 1'b0;
      ecf[m] = 1'b0;
      ecc[m] = 4'd0;
    end
    for (int b = 0; b < 8; b++) age[b] = 0;
  endtask

  // Resolves the beat currently on the inputs, as accepted at the clock edge just taken
  task automatic model_step();
    for (int m = 0; m < 4; m++) begin
      logic c;
      c = 1'b0;
      if (in_valid) begin
        for (int b = 0; b < 8; b++) begin
          int n0, n1;
          n0 = 0;
          n1 = 0;
          for (int d = 0; d < 2; d++)
            if (de[d][b]) begin
              if (dv[d][b]) n1++;
              else n0++;
            end
          if (n0 + n1 == 0) begin
            if (m == 3) begin
              age[b]++;
              if (age[b] >= 3) em[m][b] = 2'b11;
            end else em[m][b] = 2'b10;
          end else begin
            if (m == 3) age[b] = 0;
            case (m)
              1: em[m][b] = (n1 > 0) ? 2'b01 : 2'b00;
              2: em[m][b] = (n0 > 0) ? 2'b00 : 2'b01;
              default: em[m][b] = (n0 > 0 && n1 > 0) ? 2'b11 : (n1 > 0) ? 2'b01 : 2'b00;
            endcase
            if ((m == 0 || m == 3) && n0 > 0 && n1 > 0) c = 1'b1;
          end
        end
        ecf[m] = c;
      end
      eov[m] = in_valid;
      if (cnt_clr) ecc[m] = 4'd0;
      else if (in_valid && c && ecc[m] != 4'hF) ecc[m] = ecc[m] + 4'd1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("%s m%0d out_valid", tag, m), 16'(ov[m]), 16'(eov[m]));
      chk($sformatf("%s m%0d res_v", tag, m), 16'(rv[m]), 16'(exp_vec(m, 0)));
      chk($sformatf("%s m%0d res_xz", tag, m), 16'(rx[m]), 16'(exp_vec(m, 1)));
      chk($sformatf("%s m%0d conflict", tag, m), 16'(cf[m]), 16'(ecf[m]));
      chk($sformatf("%s m%0d cnt", tag, m), 16'(cc[m]), 16'(ecc[m]));
    end
  endtask

  task automatic step(input logic v, input logic [7:0] e0, input logic [7:0] v0,
                      input logic [7:0] e1, input logic [7:0] v1, input logic clr, input string tag);
    in_valid = v;
    de[0] = e0;
    dv[0] = v0;
    de[1] = e1;
    dv[1] = v1;
    cnt_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  function automatic logic [7:0] rnd_en();
    return ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
  endfunction

  task automatic random_phase(input int n, input string tag);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) != 0, rnd_en(), 8'($urandom), rnd_en(), 8'($urandom),
           $urandom_range(0, 19) == 0, tag);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 8'hFF, 8'h0F, 8'hF0, 8'hF0, 1'b0, "wire_conflict");
    chk("wire res_xz", 16'(rx[0]), 16'h00F0);
    chk("wire res_v", 16'(rv[0]), 16'h00FF);
    chk("wire conflict", 16'(cf[0]), 16'h0001);
    chk("wire cnt1", 16'(cc[0]), 16'h0001);
    step(1'b1, 8'hFF, 8'h0F, 8'hF0, 8'hF0, 1'b0, "wire_again");
    chk("wire cnt2", 16'(cc[0]), 16'h0002);

    step(1'b1, 8'hFF, 8'h01, 8'h0F, 8'h02, 1'b0, "wor_wand");
    chk("wor res_v", 16'(rv[1]), 16'h0003);
    chk("wor res_xz", 16'(rx[1]), 16'h0000);
    chk("wand res_v", 16'(rv[2]), 16'h0000);
    chk("wand res_xz", 16'(rx[2]), 16'h0000);

    step(1'b1, 8'h00, 8'h5A, 8'h00, 8'hA5, 1'b0, "undriven");
    chk("undriven res_xz", 16'(rx[0]), 16'h00FF);
    chk("undriven res_v", 16'(rv[0]), 16'h0000);
    chk("undriven conflict", 16'(cf[0]), 16'h0000);

    step(1'b1, 8'hFF, 8'hA5, 8'h00, 8'h00, 1'b0, "tri_drive");
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "tri_float");
      chk($sformatf("tri decay%0d res_v", i), 16'(rv[3]), (i < 3) ? 16'h00A5 : 16'h00FF);
      chk($sformatf("tri decay%0d res_xz", i), 16'(rx[3]), (i < 3) ? 16'h0000 : 16'h00FF);
    end
    step(1'b1, 8'hFF, 8'h3C, 8'h00, 8'h00, 1'b0, "tri_redrive");
    chk("tri redrive res_v", 16'(rv[3]), 16'h003C);
    chk("tri redrive res_xz", 16'(rx[3]), 16'h0000);

    for (int i = 0; i < 16; i++) step(1'b1, 8'hFF, 8'h0F, 8'hF0, 8'hF0, 1'b0, "sat");
    chk("cnt saturate wire", 16'(cc[0]), 16'h000F);
    chk("cnt saturate tri", 16'(cc[3]), 16'h000F);
    step(1'b1, 8'hFF, 8'h0F, 8'hF0, 8'hF0, 1'b1, "clr_with_conflict");
    chk("cnt clr priority", 16'(cc[0]), 16'h0000);
    step(1'b1, 8'hFF, 8'h0F, 8'hF0, 8'hF0, 1'b0, "after_clr");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, "gap");
      chk("gap out_valid", 16'(ov[0]), 16'h0000);
      chk("gap cnt hold", 16'(cc[0]), 16'h0001);
    end

    random_phase(300, "rand_a");

    in_valid = 1'b1;
    de[0] = 8'hFF;
    dv[0] = 8'h0F;
    de[1] = 8'hF0;
    dv[1] = 8'hF0;
    cnt_clr = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "post_reset_float");
    chk("post reset tri stays x", 16'(rx[3]), 16'h00FF);

    random_phase(300, "rand_b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
